// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, false-start rejection and 3-sample majority vote.
// Received bytes are offered on a valid/ready handshake; a dropped byte sets a sticky overrun flag.
module uart_rx #(
    parameter int unsigned DIV = 651,
    parameter int unsigned OVS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [3:0]  OS_LAST  = 4'(OVS - 1);
    localparam logic [3:0]  OS_MID   = 4'd9;

    state_t      state;
    logic        rxd_m;
    logic        rxd_s;
    logic [15:0] div_cnt;
    logic [3:0]  os_cnt;
    logic [2:0]  bit_cnt;
    logic [1:0]  samp;
    logic [7:0]  shift;
    logic        tick;
    logic        mid_tick;
    logic        end_tick;
    logic        maj;

    assign tick     = (div_cnt == DIV_LAST);
    assign mid_tick = tick && (os_cnt == OS_MID);
    assign end_tick = tick && (os_cnt == OS_LAST);
    // samp holds the samples from ticks 7 and 8; rxd_s is sample 9 on the mid tick
    assign maj      = (samp[1] & samp[0]) | (samp[1] & rxd_s) | (samp[0] & rxd_s);
    assign rx_busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= RxD;
            rxd_s <= rxd_m;
        end
    end

    // Counters sit at zero in IDLE so sampling is aligned to the detected start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            os_cnt  <= '0;
            samp    <= '1;
        end else if (state == IDLE) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            os_cnt  <= 4'(os_cnt + 4'd1);
            samp    <= {samp[0], rxd_s};
        end else begin
            div_cnt <= 16'(div_cnt + 16'd1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (mid_tick && maj) begin
                        state <= IDLE;
                    end else if (end_tick) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (mid_tick) begin
                        shift <= {maj, shift[7:1]};
                    end
                    if (end_tick) begin
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= 3'(bit_cnt + 3'd1);
                        end
                    end
                end
                STOP: begin
                    if (mid_tick) begin
                        if (maj) begin
                            // A byte accepted on this same edge frees the slot for the new one
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
